// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin N:1 AXI Stream arbiter.
// Optional macro AXIS_ARB_SRC_ID_EN: m_id carries the grant index.
module axis_rr_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_data,
    input  logic [S_COUNT*ID_WIDTH-1:0]      s_id,
    input  logic [S_COUNT*DEST_WIDTH-1:0]    s_dest,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_user,
    input  logic [S_COUNT*DATA_WIDTH/8-1:0]  s_keep,
    input  logic [S_COUNT-1:0]               s_last,
    input  logic [S_COUNT-1:0]               s_valid,
    output logic [S_COUNT-1:0]               s_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [ID_WIDTH-1:0]              m_id,
    output logic [DEST_WIDTH-1:0]            m_dest,
    output logic [USER_WIDTH-1:0]            m_user,
    output logic [DATA_WIDTH/8-1:0]          m_keep,
    output logic                             m_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [S_COUNT-1:0]               grant,
    output logic                             busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(S_COUNT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

`ifdef AXIS_ARB_SRC_ID_EN
    if (ID_WIDTH < $clog2(S_COUNT)) begin : g_id_width_chk
        $error("ID_WIDTH too narrow to carry the source index");
    end
`endif

    logic [0:0]         state_q, state_d;
    logic [S_COUNT-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     cand;
    logic               xfer_last;

    // Find the first requester at or above the pointer, wrapping at S_COUNT.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(S_COUNT)) begin
                cand = cand - (IDX_W+1)'(S_COUNT);
            end
            if (!sel_found && s_valid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Grant is one-hot and zero when idle, so it doubles as the mux select.
    always_comb begin
        m_data = '0;
        m_id   = '0;
        m_dest = '0;
        m_user = '0;
        m_keep = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q[i]) begin
                m_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifndef AXIS_ARB_SRC_ID_EN
                m_id   = s_id[i*ID_WIDTH +: ID_WIDTH];
`endif
                m_dest = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
                m_user = s_user[i*USER_WIDTH +: USER_WIDTH];
                m_keep = s_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
`ifdef AXIS_ARB_SRC_ID_EN
        if (state_q == BUSY) begin
            m_id = ID_WIDTH'(gidx_q);
        end
`endif
    end

    assign m_valid   = |(grant_q & s_valid);
    assign m_last    = |(grant_q & s_last);
    assign s_ready   = grant_q & {S_COUNT{m_ready}};
    assign grant     = grant_q;
    assign busy      = (state_q == BUSY);
    assign xfer_last = m_valid & m_ready & m_last;

    // Lock a grant in IDLE; release it after the tlast handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d          = BUSY;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                end
            end
            BUSY: begin
                if (xfer_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                    if (gidx_q == IDX_W'(S_COUNT - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gidx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed self-checking bench for axis_rr_arbiter.
// Expected m_id follows AXIS_ARB_SRC_ID_EN when it is defined.
module tb_axis_rr_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

`ifdef AXIS_ARB_SRC_ID_EN
    localparam logic [IW-1:0] ID3 = 2'd3;
`else
    localparam logic [IW-1:0] ID3 = 2'd0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [S*DW-1:0] s_data;
    logic [S*IW-1:0] s_id;
    logic [S-1:0]    s_dest;
    logic [S-1:0]    s_user;
    logic [S-1:0]    s_keep;
    logic [S-1:0]    s_last;
    logic [S-1:0]    s_valid;
    logic [S-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic [IW-1:0]   m_id;
    logic [0:0]      m_dest;
    logic [0:0]      m_user;
    logic [0:0]      m_keep;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;
    logic [S-1:0]    grant;
    logic            busy;

    int cmp_n = 0;
    int err_n = 0;

    axis_rr_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .DEST_WIDTH(1), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_id(s_id), .s_dest(s_dest),
        .s_user(s_user), .s_keep(s_keep), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_id(m_id), .m_dest(m_dest),
        .m_user(m_user), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int p, input logic [7:0] d,
                         input logic l, input logic v);
        s_data[p*DW +: DW] = d;
        s_last[p]          = l;
        s_valid[p]         = v;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        s_valid = 4'b1111;
        s_data  = 32'h44332211;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            cmp_n++;
            if (s_ready !== 4'b0000) begin
                err_n++;
                $display("FAIL rst_s_ready got %b want 0000", s_ready);
            end
            cmp_n++;
            if (m_valid !== 1'b0) begin
                err_n++;
                $display("FAIL rst_m_valid got %b want 0", m_valid);
            end
            cmp_n++;
            if (grant !== 4'b0000) begin
                err_n++;
                $display("FAIL rst_grant got %b want 0000", grant);
            end
            cmp_n++;
            if (busy !== 1'b0) begin
                err_n++;
                $display("FAIL rst_busy got %b want 0", busy);
            end
            cmp_n++;
            if (m_data !== 8'h00) begin
                err_n++;
                $display("FAIL rst_m_data got %h want 00", m_data);
            end
        end
        reset = 1'b0;
        step();
        #1;
        cmp_n++;
        if (grant !== 4'b0001) begin
            err_n++;
            $display("FAIL rst_first_grant got %b want 0001", grant);
        end
        cmp_n++;
        if (m_data !== 8'h11) begin
            err_n++;
            $display("FAIL rst_first_data got %h want 11", m_data);
        end
        s_valid = 4'b0001;
        s_last  = 4'b0001;
        step();
        s_valid = 4'b0000;
        s_last  = 4'b0000;
        #1;
        cmp_n++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            err_n++;
            $display("FAIL rst_release got busy=%b grant=%b want 0 0000",
                     busy, grant);
        end
    endtask

    task automatic test_single();
        s_keep = 4'b0100;
        s_dest = 4'b0100;
        drive(2, 8'hA1, 1'b0, 1'b1);
        #1;
        cmp_n++;
        if (s_ready !== 4'b0000 || m_valid !== 1'b0) begin
            err_n++;
            $display("FAIL single_idle got rdy=%b vld=%b want 0000 0",
                     s_ready, m_valid);
        end
        step();
        #1;
        cmp_n++;
        if (grant !== 4'b0100) begin
            err_n++;
            $display("FAIL single_grant got %b want 0100", grant);
        end
        cmp_n++;
        if (s_ready !== 4'b0100) begin
            err_n++;
            $display("FAIL single_ready got %b want 0100", s_ready);
        end
        cmp_n++;
        if (m_keep !== 1'b1 || m_dest !== 1'b1) begin
            err_n++;
            $display("FAIL single_side got keep=%b dest=%b want 1 1",
                     m_keep, m_dest);
        end
        cmp_n++;
        if (m_data !== 8'hA1) begin
            err_n++;
            $display("FAIL single_b1 got %h want a1", m_data);
        end
        step();
        drive(2, 8'hA2, 1'b0, 1'b1);
        #1;
        cmp_n++;
        if (m_data !== 8'hA2) begin
            err_n++;
            $display("FAIL single_b2 got %h want a2", m_data);
        end
        step();
        drive(2, 8'hA3, 1'b1, 1'b1);
        #1;
        cmp_n++;
        if (m_data !== 8'hA3 || m_last !== 1'b1) begin
            err_n++;
            $display("FAIL single_b3 got %h/%b want a3/1", m_data, m_last);
        end
        step();
        drive(2, 8'h00, 1'b0, 1'b0);
        #1;
        cmp_n++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            err_n++;
            $display("FAIL single_end got busy=%b grant=%b want 0 0000",
                     busy, grant);
        end
        s_keep = '0;
        s_dest = '0;
    endtask

    task automatic test_single_beat();
        drive(3, 8'h3C, 1'b1, 1'b1);
        step();
        #1;
        cmp_n++;
        if (grant !== 4'b1000) begin
            err_n++;
            $display("FAIL sbeat_grant got %b want 1000", grant);
        end
        cmp_n++;
        if (m_data !== 8'h3C || m_last !== 1'b1) begin
            err_n++;
            $display("FAIL sbeat_beat got %h/%b want 3c/1", m_data, m_last);
        end
        step();
        drive(3, 8'h00, 1'b0, 1'b0);
        #1;
        cmp_n++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            err_n++;
            $display("FAIL sbeat_end got busy=%b grant=%b want 0 0000",
                     busy, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [S-1:0]  eg [15];
        logic [DW-1:0] ed [15];
        logic [S-1:0]  hs;
        int            beat [S];
        eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
               4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
        ed = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00, 8'h20,
               8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h01};
        beat = '{default: 0};
        for (int c = 0; c < 15; c++) begin
            for (int p = 0; p < S; p++) begin
                drive(p, 8'(16*p + beat[p]), beat[p] == 1, 1'b1);
            end
            #1;
            cmp_n++;
            if (grant !== eg[c] || s_ready !== eg[c]) begin
                err_n++;
                $display("FAIL rr_grant c%0d got %b/%b want %b",
                         c, grant, s_ready, eg[c]);
            end
            cmp_n++;
            if (m_data !== ed[c] || m_valid !== (eg[c] != 0)) begin
                err_n++;
                $display("FAIL rr_data c%0d got %h/%b want %h",
                         c, m_data, m_valid, ed[c]);
            end
            hs = s_ready & s_valid;
            step();
            for (int p = 0; p < S; p++) begin
                if (hs[p]) beat[p] = 1 - beat[p];
            end
        end
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
    endtask

    task automatic test_backpressure();
        logic          mr  [4];
        logic [DW-1:0] dat [4];
        logic          lst [4];
        mr  = '{1'b1, 1'b0, 1'b0, 1'b1};
        dat = '{8'hB0, 8'hB1, 8'hB1, 8'hB1};
        lst = '{1'b0, 1'b1, 1'b1, 1'b1};
        drive(1, 8'hB0, 1'b0, 1'b1);
        drive(2, 8'hC0, 1'b1, 1'b1);
        step();
        for (int c = 0; c < 4; c++) begin
            m_ready = mr[c];
            drive(1, dat[c], lst[c], 1'b1);
            #1;
            cmp_n++;
            if (grant !== 4'b0010) begin
                err_n++;
                $display("FAIL bp_grant c%0d got %b want 0010", c, grant);
            end
            cmp_n++;
            if (s_ready !== {2'b00, mr[c], 1'b0}) begin
                err_n++;
                $display("FAIL bp_ready c%0d got %b want %b",
                         c, s_ready, {2'b00, mr[c], 1'b0});
            end
            cmp_n++;
            if (m_valid !== 1'b1 || m_data !== dat[c]) begin
                err_n++;
                $display("FAIL bp_data c%0d got %b/%h want 1/%h",
                         c, m_valid, m_data, dat[c]);
            end
            step();
        end
        m_ready = 1'b1;
        s_valid = '0;
        s_last  = '0;
        #1;
        cmp_n++;
        if (busy !== 1'b0) begin
            err_n++;
            $display("FAIL bp_end got busy=%b want 0", busy);
        end
    endtask

    task automatic test_source_drop();
        drive(0, 8'hD0, 1'b0, 1'b1);
        step();
        #1;
        cmp_n++;
        if (grant !== 4'b0001 || m_data !== 8'hD0) begin
            err_n++;
            $display("FAIL drop_start got %b/%h want 0001/d0", grant, m_data);
        end
        step();
        s_valid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            cmp_n++;
            if (busy !== 1'b1 || grant !== 4'b0001) begin
                err_n++;
                $display("FAIL drop_hold c%0d got busy=%b grant=%b want 1 0001",
                         c, busy, grant);
            end
            cmp_n++;
            if (m_valid !== 1'b0) begin
                err_n++;
                $display("FAIL drop_valid c%0d got %b want 0", c, m_valid);
            end
            step();
        end
        drive(0, 8'hD1, 1'b1, 1'b1);
        #1;
        cmp_n++;
        if (m_valid !== 1'b1 || m_data !== 8'hD1 || m_last !== 1'b1) begin
            err_n++;
            $display("FAIL drop_resume got %b/%h/%b want 1/d1/1",
                     m_valid, m_data, m_last);
        end
        step();
        drive(0, 8'h00, 1'b0, 1'b0);
        #1;
        cmp_n++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            err_n++;
            $display("FAIL drop_end got busy=%b grant=%b want 0 0000",
                     busy, grant);
        end
    endtask

    task automatic test_src_id();
        s_id = '0;
        drive(3, 8'hE0, 1'b0, 1'b1);
        step();
        #1;
        cmp_n++;
        if (grant !== 4'b1000 || m_id !== ID3) begin
            err_n++;
            $display("FAIL id_b1 got %b/%0d want 1000/%0d", grant, m_id, ID3);
        end
        step();
        drive(3, 8'hE1, 1'b1, 1'b1);
        #1;
        cmp_n++;
        if (m_id !== ID3 || m_data !== 8'hE1) begin
            err_n++;
            $display("FAIL id_b2 got %0d/%h want %0d/e1", m_id, m_data, ID3);
        end
        step();
        drive(3, 8'h00, 1'b0, 1'b0);
        #1;
        cmp_n++;
        if (busy !== 1'b0 || m_id !== 2'd0) begin
            err_n++;
            $display("FAIL id_end got busy=%b id=%0d want 0 0", busy, m_id);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_data  = '0;
        s_id    = '0;
        s_dest  = '0;
        s_user  = '0;
        s_keep  = '0;
        s_last  = '0;
        s_valid = '0;
        m_ready = 1'b1;
        test_reset();
        test_single();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_source_drop();
        test_src_id();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 packet-level round-robin arbiter for the AXI Stream switch.
- Grants one slave input at a time to the single master output and holds the grant until the tlast beat completes its handshake.
- Combinational passthrough datapath while granted; arbitration decision registered.
- Used per output port of the switch, upstream of the output interface.

Parameters:
S_COUNT, 4, number of slave (input) ports, 2..16
DATA_WIDTH, 8, tdata width, multiple of 8
ID_WIDTH, 1, tid width
DEST_WIDTH, 1, tdest width
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_data  in  S_COUNT*DATA_WIDTH  packed input tdata, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_id  in  S_COUNT*ID_WIDTH  packed tid
s_dest  in  S_COUNT*DEST_WIDTH  packed tdest
s_user  in  S_COUNT*USER_WIDTH  packed tuser
s_keep  in  S_COUNT*DATA_WIDTH/8  packed tkeep
s_last  in  S_COUNT  tlast per port
s_valid  in  S_COUNT  tvalid per port
s_ready  out  S_COUNT  tready per port
m_data  out  DATA_WIDTH  output tdata
m_id  out  ID_WIDTH  output tid
m_dest  out  DEST_WIDTH  output tdest
m_user  out  USER_WIDTH  output tuser
m_keep  out  DATA_WIDTH/8  output tkeep
m_last  out  1  output tlast
m_valid  out  1  output tvalid
m_ready  in  1  output tready
grant  out  S_COUNT  one-hot current grant, 0 when idle
busy  out  1  high in BUSY state

Behaviour:
- Reset (sampled at posedge clk): state=IDLE, grant=0, rr pointer=0, busy=0. Outputs then evaluate to s_ready=0, m_valid=0, and all m_* payload fields 0.
- FSM states:
  - IDLE:
    - If any s_valid is set, select the first requester at or after the rr pointer, searching upward with wrap from S_COUNT-1 to 0.
    - Register the one-hot grant and go to BUSY next cycle.
    - No handshake occurs in IDLE: s_ready=0, m_valid=0.
  - BUSY:
    - m_* = granted port's fields (combinational mux).
    - m_valid = s_valid[g]; s_ready[g] = m_ready; all other s_ready = 0.
    - Beat transfers when m_valid & m_ready.
    - On a transfer with m_last=1: go to IDLE, clear grant, set rr pointer = (g+1) mod S_COUNT.
- When not BUSY, all m_* payload outputs are driven to 0.
- Latency:
  - 1 cycle from s_valid rising in IDLE to m_valid.
  - 0-cycle combinational path s→m in BUSY.
  - One mandatory idle cycle between packets.
- Stability: the grant never changes mid-packet. Upstream valid/payload stability under backpressure is therefore preserved at the output.
- A single-beat packet (first beat has last=1) returns to IDLE after that beat.
- s_valid dropping mid-packet on the granted port: stay BUSY and wait. There is no timeout.
- Fairness: after a port's packet completes it has lowest priority. With all ports requesting, the grant order is 0,1,2,3,0,...
- Requests on non-granted ports are ignored; their s_ready stays 0.
- Reset asserted mid-packet: grant is dropped at the next edge and the rest of the packet is abandoned. Upstream must also be reset.
- S_COUNT is not a power of two: pointer wraps at S_COUNT; no out-of-range index is ever selected.

Optional Feature:
- Macro AXIS_ARB_SRC_ID_EN.
- Defined: m_id = grant index (binary, zero-extended) instead of s_id[g]. A width check must be an elaboration error if ID_WIDTH < $clog2(S_COUNT).
- Undefined: m_id = s_id[g] unchanged.

Test Plan:
- Reset: hold reset 3 cycles with all s_valid=1 -> s_ready=0, m_valid=0, grant=0, busy=0 throughout; first grant after release = 4'b0001.
- Single requester: port 2 sends a 3-beat packet (data 0xA1,0xA2,0xA3, last on beat 3), m_ready=1 -> grant=4'b0100 one cycle after s_valid; m_data sequence A1,A2,A3; IDLE on the cycle after the last beat.
- Round-robin: all 4 ports continuously send 2-beat packets -> grant order 0,1,2,3,0 with exactly one idle cycle between packets; no interleaving of beats.
- Backpressure: m_ready toggles 1,0,0,1 during port 1's packet -> s_ready[1] mirrors m_ready; m_data/m_valid stable on stalled cycles; other s_ready=0.
- Single-beat and source drop: port 3 sends 1 beat with last=1 -> back to IDLE next cycle. Port 0 then deasserts s_valid for 5 cycles mid-packet -> busy stays 1, grant stays 4'b0001, and the packet resumes intact.
- With AXIS_ARB_SRC_ID_EN (ID_WIDTH=2): packet from port 3 with s_id=0 -> m_id=2'd3 on every beat; without the macro -> m_id=0.
